// File: rtl/vector_pkg.sv
// vector_pkg: shared opcodes, geometry and state encodings for the vector sequencer.
package vector_pkg;
    localparam int LANES = 16;
    localparam int EW    = 16;
    localparam int VW    = LANES * EW;

    localparam logic [3:0] VADD = 4'b0000;
    localparam logic [3:0] VDOT = 4'b0001;
    localparam logic [3:0] SMUL = 4'b0010;
    localparam logic [3:0] SST  = 4'b0011;
    localparam logic [3:0] VLD  = 4'b0100;
    localparam logic [3:0] VST  = 4'b0101;
    localparam logic [3:0] SLL  = 4'b0110;
    localparam logic [3:0] SLH  = 4'b0111;
    localparam logic [3:0] NOP  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {MAC_ADD, MAC_MUL, MAC_MACC} mac_sel_e;

    function automatic logic is_vec(input logic [3:0] op);
        return op == VADD || op == VDOT || op == SMUL;
    endfunction
endpackage

// File: rtl/vector_op_sequencer_lane_mac.sv
// lane_mac: single 16-bit lane add / multiply / multiply-accumulate, results truncated to EW bits.
module lane_mac
    import vector_pkg::*;
(
    input  logic [EW-1:0] a_i,
    input  logic [EW-1:0] b_i,
    input  logic [EW-1:0] acc_in_i,
    input  mac_sel_e      sel_i,
    output logic [EW-1:0] y_o
);
    logic [EW-1:0] prod;
    always_comb begin
        prod = a_i * b_i;
        y_o  = sel_i == MAC_ADD ? a_i + b_i : sel_i == MAC_MUL ? prod : acc_in_i + prod;
    end
endmodule

// File: rtl/vector_op_sequencer.sv
// vector_op_sequencer: steps one shared lane_mac across 16 lanes for VADD/VDOT/SMUL,
// pulsing done for one cycle with the assembled 256-bit result.
module vector_op_sequencer
    import vector_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic [VW-1:0] op_1,
    input  logic [VW-1:0] op_2,
    output logic          busy,
    output logic          done,
    output logic [VW-1:0] result
);
    state_e        state_q, state_d;
    logic [3:0]    lane_q, lane_d;
    logic [3:0]    op_q, op_d;
    logic [VW-1:0] a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
    logic [EW-1:0] acc_q, acc_d, mac_a, mac_b, mac_y;
    mac_sel_e      mac_sel;

    // SMUL broadcasts the scalar in lane 0 of A against every lane of B
    assign mac_a   = op_q == SMUL ? a_q[EW-1:0] : a_q[lane_q*EW +: EW];
    assign mac_b   = b_q[lane_q*EW +: EW];
    assign mac_sel = op_q == VADD ? MAC_ADD : op_q == SMUL ? MAC_MUL : MAC_MACC;

    lane_mac u_mac (
        .a_i      (mac_a),
        .b_i      (mac_b),
        .acc_in_i (acc_q),
        .sel_i    (mac_sel),
        .y_o      (mac_y)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (is_vec(opcode)) begin
                    a_d     = op_1;
                    b_d     = op_2;
                    op_d    = opcode;
                    work_d  = '0;
                    acc_d   = '0;
                    lane_d  = '0;
                    state_d = S_RUN;
                end else begin
                    work_d   = '0;
                    result_d = '0;
                    state_d  = S_DONE;
                end
            end
            S_RUN: begin
                if (op_q == VDOT) acc_d = mac_y;
                else work_d[lane_q*EW +: EW] = mac_y;
                lane_d = lane_q + 4'd1;
                if (lane_q == 4'(LANES-1)) begin
                    state_d  = S_DONE;
                    result_d = op_q == VDOT ? {{(VW-EW){1'b0}}, acc_d} : work_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != S_IDLE;
    assign done   = state_q == S_DONE;
    assign result = result_q;
endmodule

// File: tb/tb_vector_op_sequencer.sv
// tb_vector_op_sequencer: directed and randomized checks of vector_op_sequencer against a lane-level reference model.
module tb_vector_op_sequencer;
    import vector_pkg::*;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]   opcode = '0;
    logic [255:0] op_1 = '0, op_2 = '0, result;
    logic         busy, done;
    int           total = 0, bad = 0;

    vector_op_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .op_1   (op_1),
        .op_2   (op_2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // element-wise arithmetic in wide integers, reduced modulo 2^16 at the end
    function automatic logic [255:0] model(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b);
        logic [255:0]    r = '0;
        longint unsigned s = 0, x, y, k;
        k = a[15:0];
        for (int i = 0; i < 16; i++) begin
            x = a[16*i +: 16];
            y = b[16*i +: 16];
            if (op == VADD) r[16*i +: 16] = 16'((x + y) % 65536);
            else if (op == SMUL) r[16*i +: 16] = 16'((k * y) % 65536);
            else if (op == VDOT) s += x * y;
        end
        if (op == VDOT) r[15:0] = 16'(s % 65536);
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [255:0] a, input logic [255:0] b,
                          input int pulse_at, input int change_at);
        logic [255:0] exp;
        int lat, want_lat;
        exp      = model(op, a, b);
        want_lat = is_vec(op) ? 16 : 0;
        @(negedge clk);
        start = 1'b1; opcode = op; op_1 = a; op_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 256'(busy), 256'd1);
        lat = 0;
        while (!done && lat < 40) begin
            start = (lat == pulse_at);
            opcode = (lat == pulse_at) ? VADD : opcode;
            if (lat == change_at) begin
                op_1 = rand256(); op_2 = rand256(); opcode = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 256'(lat), 256'(want_lat));
        check({tag, "_res"}, result, exp);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, "_nodone"}, 256'({busy, done}), 256'd0);
        end
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        logic [255:0] a, b, exp;
        logic [3:0]   op;
        int t, last, n;

        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle", {result[253:0], busy, done}, 256'd0);
        end

        for (int i = 0; i < 16; i++) begin
            a[16*i +: 16] = 16'(i);
            b[16*i +: 16] = 16'd100;
        end
        run_op("vadd_ramp", VADD, a, b, -1, -1);
        check("vadd_l5", 256'(result[95:80]), 256'd105);
        a[255:240] = 16'hFFFF; b[255:240] = 16'h0002;
        run_op("vadd_wrap", VADD, a, b, -1, -1);
        check("vadd_l15", 256'(result[255:240]), 256'd1);

        run_op("vdot_240", VDOT, {16{16'd3}}, {16{16'd5}}, -1, -1);
        check("vdot_240v", result, 256'd240);
        run_op("vdot_trunc", VDOT, {16{16'h0100}}, {16{16'h0100}}, -1, -1);
        check("vdot_truncv", result, 256'd0);

        a = rand256(); a[15:0] = 16'd7;
        for (int i = 0; i < 16; i++) b[16*i +: 16] = 16'(i);
        run_op("smul_chg", SMUL, a, b, -1, 2);
        check("smul_l9", 256'(result[159:144]), 256'd63);

        run_op("vadd_busy", VADD, rand256(), rand256(), 4, -1);
        run_op("sll", SLL, rand256(), rand256(), -1, -1);
        check("sll_zero", result, 256'd0);

        a = rand256(); b = rand256(); exp = model(VADD, a, b);
        @(negedge clk);
        start = 1'b1; opcode = VADD; op_1 = a; op_2 = b;
        t = 0; last = -1; n = 0;
        while (n < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (done) begin
                check("held_res", result, exp);
                if (last >= 0) check("held_gap", 256'(t - last), 256'd18);
                last = t;
                n++;
            end
        end
        start = 1'b0;
        check("held_cnt", 256'(n), 256'd3);
        repeat (2) @(posedge clk);

        @(negedge clk);
        start = 1'b1; opcode = VDOT; op_1 = rand256(); op_2 = rand256();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", {result[253:0], busy, done}, 256'd0);
        @(negedge clk) rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n += int'(done);
        end
        check("rst_nodone", 256'(n), 256'd0);
        run_op("post_rst", VADD, rand256(), rand256(), -1, -1);

        for (int i = 0; i < 20; i++) begin
            n  = $urandom_range(0, 5);
            op = n < 3 ? 4'(n) : 4'($urandom_range(3, 15));
            run_op("rand", op, rand256(), rand256(), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
